// File: rtl/w0rm_core_ifetch_pkg.sv
// Shared fetch-unit definitions: FSM encodings and PC step.
package w0rm_core_ifetch_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned PC_STEP = 2;

endpackage

// File: rtl/w0rm_core_ifetch_fifo.sv
// Two-entry in-order FIFO with synchronous flush; entry 0 is the head.
module w0rm_core_ifetch_fifo #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = wdata;
          else               e1_d = wdata;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // count stays; the new word lands behind any survivor
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = wdata;
          end else begin
            e0_d = wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = e0_q;
  assign valid = (cnt_q != 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/w0rm_core_ifetch.sv
// Instruction fetch: credit-limited requests, in-order response buffer,
// redirect with drain of stale responses.
module w0rm_core_ifetch
  import w0rm_core_ifetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INST_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] branch_next_pc,
  input  logic                  branch_next_pc_valid,
  output logic [ADDR_WIDTH-1:0] inst_mem_addr,
  output logic                  inst_mem_read,
  input  logic                  inst_mem_ready,
  input  logic [INST_WIDTH-1:0] inst_mem_data,
  input  logic                  inst_mem_data_valid,
  input  logic                  decode_ready,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [1:0]            outst_q, outst_d;
  logic [1:0]            disc_q, disc_d;

  logic [1:0]            fifo_cnt;
  logic                  fifo_valid;
  logic                  pop, push, accept, redirect, resp;
  logic [2:0]            inflight;
  logic [ADDR_WIDTH-1:0] target;

  always_comb begin
    redirect = branch_next_pc_valid;
    resp     = inst_mem_data_valid;
    target   = branch_next_pc & ALIGN;
    pop      = fifo_valid && decode_ready && !redirect;
    inflight = {1'b0, outst_q} + {1'b0, fifo_cnt} - {2'b0, pop};

    inst_mem_read = (state_q == ST_FETCH) && !redirect &&
                    (inflight < 3'd2);
    accept = inst_mem_read && inst_mem_ready;
    push   = resp && (disc_q == 2'd0);

    outst_d = outst_q + {1'b0, accept} - {1'b0, resp};
    disc_d  = disc_q;
    if (resp && disc_q != 2'd0) disc_d = disc_q - 2'd1;

    fetch_pc_d = fetch_pc_q;
    if (accept) fetch_pc_d = fetch_pc_q + STEP;
    // rsp_pc tracks the PC of the next response that will be kept
    rsp_pc_d = rsp_pc_q;
    if (push) rsp_pc_d = rsp_pc_q + STEP;

    state_d = state_q;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (redirect && outst_d != 2'd0) state_d = ST_DRAIN;
      ST_DRAIN: if (disc_d == 2'd0) state_d = ST_FETCH;
      default:  state_d = ST_RST;
    endcase

    if (redirect) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      if (state_q != ST_DRAIN) disc_d = outst_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RST;
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR & ALIGN;
      outst_q    <= 2'd0;
      disc_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  assign inst_mem_addr = fetch_pc_q & ALIGN;

  w0rm_core_ifetch_fifo #(
    .WIDTH(INST_WIDTH + ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({inst_mem_data, rsp_pc_q}),
    .rdata ({inst_data, inst_pc}),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );

  assign inst_valid = fifo_valid;

endmodule

// File: tb/tb_w0rm_core_ifetch.sv
// Bench for w0rm_core_ifetch: vector table, directed redirect cases,
// random traffic against an in-order memory model and stream scoreboard.
module tb_w0rm_core_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] branch_next_pc;
  logic        branch_next_pc_valid;
  logic [31:0] inst_mem_addr;
  logic        inst_mem_read;
  logic        inst_mem_ready;
  logic [15:0] inst_mem_data;
  logic        inst_mem_data_valid;
  logic        decode_ready;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  w0rm_core_ifetch dut (
    .clk                  (clk),
    .reset                (reset),
    .branch_next_pc       (branch_next_pc),
    .branch_next_pc_valid (branch_next_pc_valid),
    .inst_mem_addr        (inst_mem_addr),
    .inst_mem_read        (inst_mem_read),
    .inst_mem_ready       (inst_mem_ready),
    .inst_mem_data        (inst_mem_data),
    .inst_mem_data_valid  (inst_mem_data_valid),
    .decode_ready         (decode_ready),
    .inst_valid           (inst_valid),
    .inst_data            (inst_data),
    .inst_pc              (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    bit          dr;
    bit          rd;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  req_t        pend[$];
  vec_t        tbl[14];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          delivered = 0;
  bit          hold = 0;
  bit          mem_rdy = 1;
  bit          dr = 1;
  bit          br_v = 0;
  logic [31:0] br_pc = '0;
  logic [31:0] exp_req = '0;
  logic [31:0] exp_out = '0;

  function automatic logic [15:0] memf(input logic [31:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[23:16], 8'h00};
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
               n, act, exp, cyc);
    end
  endtask

  task automatic drive();
    req_t r;
    if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      inst_mem_data_valid = 1'b1;
      inst_mem_data       = memf(r.addr);
    end else begin
      inst_mem_data_valid = 1'b0;
      inst_mem_data       = 16'($urandom);
    end
    inst_mem_ready       = mem_rdy;
    decode_ready         = dr;
    branch_next_pc_valid = br_v;
    branch_next_pc       = br_pc;
    #1;
  endtask

  task automatic clock();
    req_t r;
    if (inst_valid && dr && !br_v) begin
      chk("deliver_pc", 64'(inst_pc), 64'(exp_out));
      chk("deliver_data", 64'(inst_data), 64'(memf(exp_out)));
      exp_out = exp_out + 32'd2;
      delivered++;
    end
    if (inst_mem_read && mem_rdy) begin
      chk("req_addr", 64'(inst_mem_addr), 64'(exp_req));
      r.addr = inst_mem_addr;
      r.due  = cyc + lat;
      pend.push_back(r);
      chk("credit_le2", 64'(pend.size() <= 2), 64'd1);
      exp_req = exp_req + 32'd2;
    end
    if (br_v) begin
      chk("redir_noread", 64'(inst_mem_read), 64'd0);
      exp_req = br_pc & ~32'h1;
      exp_out = exp_req;
    end
    @(posedge clk);
    cyc++;
    br_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill2(input string n);
    hold = 1'b1;
    for (int i = 0; i < 20 && pend.size() < 2; i++) begin
      drive();
      clock();
    end
    chk(n, 64'(pend.size()), 64'd2);
  endtask

  task automatic wait_first(input string n, input logic [31:0] pc);
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      drive();
      if (inst_valid) begin
        seen = 1;
        chk(n, 64'(inst_pc), 64'(pc));
      end
      clock();
    end
    chk({n, "_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tbl[0]  = '{1, 0, 32'd0,  0, 32'd0};
    tbl[1]  = '{1, 1, 32'd0,  0, 32'd0};
    tbl[2]  = '{1, 1, 32'd2,  0, 32'd0};
    tbl[3]  = '{1, 1, 32'd4,  1, 32'd0};
    tbl[4]  = '{1, 1, 32'd6,  1, 32'd2};
    tbl[5]  = '{1, 1, 32'd8,  1, 32'd4};
    tbl[6]  = '{0, 0, 32'd10, 1, 32'd6};
    tbl[7]  = '{0, 0, 32'd10, 1, 32'd6};
    tbl[8]  = '{0, 0, 32'd10, 1, 32'd6};
    tbl[9]  = '{0, 0, 32'd10, 1, 32'd6};
    tbl[10] = '{0, 0, 32'd10, 1, 32'd6};
    tbl[11] = '{1, 1, 32'd10, 1, 32'd6};
    tbl[12] = '{1, 1, 32'd12, 1, 32'd8};
    tbl[13] = '{1, 1, 32'd14, 1, 32'd10};

    reset = 1'b1;
    branch_next_pc = '0;
    branch_next_pc_valid = 1'b0;
    inst_mem_ready = 1'b0;
    inst_mem_data = '0;
    inst_mem_data_valid = 1'b0;
    decode_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_read", 64'(inst_mem_read), 64'd0);
    chk("rst_addr", 64'(inst_mem_addr), 64'd0);
    chk("rst_pc", 64'(inst_pc), 64'd0);
    chk("rst_data", 64'(inst_data), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      dr = tbl[i].dr;
      drive();
      chk($sformatf("tbl%0d_read", i), 64'(inst_mem_read), 64'(tbl[i].rd));
      chk($sformatf("tbl%0d_addr", i), 64'(inst_mem_addr), 64'(tbl[i].addr));
      chk($sformatf("tbl%0d_valid", i), 64'(inst_valid), 64'(tbl[i].vld));
      if (tbl[i].vld)
        chk($sformatf("tbl%0d_pc", i), 64'(inst_pc), 64'(tbl[i].pc));
      clock();
    end

    // redirect with two requests outstanding
    dr = 1'b1;
    fill2("r24_fill");
    br_v = 1'b1;
    br_pc = 32'h100;
    drive();
    clock();
    drive();
    chk("r24_flush_valid", 64'(inst_valid), 64'd0);
    chk("r24_drain_read", 64'(inst_mem_read), 64'd0);
    clock();
    hold = 1'b0;
    wait_first("r24_first_pc", 32'h100);

    // second redirect while still draining
    fill2("r26_fill");
    br_v = 1'b1;
    br_pc = 32'h100;
    drive();
    clock();
    hold = 1'b0;
    drive();
    chk("r26_stale_valid", 64'(inst_valid), 64'd0);
    clock();
    hold = 1'b1;
    br_v = 1'b1;
    br_pc = 32'h200;
    drive();
    clock();
    hold = 1'b0;
    wait_first("r26_first_pc", 32'h200);

    // redirect to an odd target with nothing in flight
    mem_rdy = 1'b0;
    for (int i = 0; i < 10 && pend.size() > 0; i++) begin
      drive();
      clock();
    end
    chk("r25_idle", 64'(pend.size()), 64'd0);
    br_v = 1'b1;
    br_pc = 32'h101;
    drive();
    clock();
    drive();
    chk("r25_read", 64'(inst_mem_read), 64'd1);
    chk("r25_addr", 64'(inst_mem_addr), 64'h100);
    clock();

    // fetch_pc wrap
    br_v = 1'b1;
    br_pc = 32'hFFFF_FFFE;
    drive();
    clock();
    mem_rdy = 1'b1;
    drive();
    chk("r27_top_addr", 64'(inst_mem_addr), 64'hFFFF_FFFE);
    clock();
    drive();
    chk("r27_wrap_read", 64'(inst_mem_read), 64'd1);
    chk("r27_wrap_addr", 64'(inst_mem_addr), 64'd0);
    clock();

    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      dr      = ($urandom % 4) != 0;
      mem_rdy = ($urandom % 3) != 0;
      hold    = ($urandom % 5) == 0;
      lat     = int'($urandom_range(1, 3));
      br_v    = ($urandom % 30) == 0;
      br_pc   = $urandom;
      drive();
      clock();
    end
    chk("rand_progress", 64'((delivered - d0) > 200), 64'd1);

    // reset in the middle of traffic
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(inst_valid), 64'd0);
    chk("mid_rst_read", 64'(inst_mem_read), 64'd0);
    chk("mid_rst_addr", 64'(inst_mem_addr), 64'd0);
    pend.delete();
    hold = 1'b0;
    lat = 1;
    dr = 1'b1;
    mem_rdy = 1'b1;
    br_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_req = '0;
    exp_out = '0;
    d0 = delivered;
    for (int i = 0; i < 20; i++) begin
      drive();
      clock();
    end
    chk("post_rst_count", 64'(delivered - d0), 64'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
